// File: rtl/tiny_rv_wb_ram_if.sv
// Wishbone B4 pipelined data-bus bundle between the exec-stage memory unit (master)
// and tiny_rv_wb_ram (slave).
//   cyc, stb, we, addr[29:0], wdata[31:0], sel[3:0] : master -> slave request
//   stall, ack, err, rdata[31:0]                     : slave -> master response
interface tiny_rv_wb_ram_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        stall;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output cyc, stb, we, addr, wdata, sel,
    input  stall, ack, err, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, wdata, sel,
    output stall, ack, err, rdata
  );
endinterface

// File: rtl/tiny_rv_wb_ram.sv
// Wishbone B4 pipelined RAM responder for the core's data-memory bus.
// Requests are queued in order and each is answered with exactly one ack (in range)
// or err (out of range) a fixed number of cycles after it reaches the queue head.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   wb (slave)     : cyc/stb/we/addr/wdata/sel in; stall/ack/err/rdata out (all registered)
module tiny_rv_wb_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  tiny_rv_wb_ram_if.slave   wb
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned QP_W  = $clog2(QUEUE_DEPTH);
  localparam int unsigned QC_W  = QP_W + 1;
  localparam int unsigned WC_W  = 4;

  localparam logic [29:0]     BASE  = 30'(BASE_ADDR);
  localparam logic [29:0]     DEPTH = 30'(DEPTH_WORDS);
  localparam logic [QC_W-1:0] QFULL = QC_W'(QUEUE_DEPTH);
  localparam logic [WC_W-1:0] WLOAD = (WAIT_STATES == 0) ? '0 : WC_W'(WAIT_STATES - 1);

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        oor;
  } req_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  req_t            q_mem [QUEUE_DEPTH];
  logic [QP_W-1:0] rd_ptr, wr_ptr;
  logic [QC_W-1:0] count, count_nxt;
  state_t          state, state_nxt;
  logic [WC_W-1:0] wcnt, wcnt_nxt;
  logic            stall_q, ack_q, err_q;
  logic [31:0]     rdata_q;
  logic [31:0]     ram [DEPTH_WORDS];

  logic            push_c, fire_c, start_c;
  logic [30:0]     off_c;
  req_t            req_c, head_c;
  logic [IDX_W-1:0] idx_c;

  // Incoming request, with range check done once at accept time (bit 30 = borrow).
  always_comb begin
    off_c  = {1'b0, wb.addr} - {1'b0, BASE};
    req_c  = '{we: wb.we, addr: wb.addr, data: wb.wdata, sel: wb.sel,
               oor: off_c[30] | (off_c[29:0] >= DEPTH)};
    push_c = wb.cyc & wb.stb & ~stall_q;
    head_c = q_mem[rd_ptr];
    idx_c  = IDX_W'(head_c.addr - BASE);
  end

  // Next state / wait counter. fire_c marks the edge that loads the response
  // registers and pops the head, so RESP is the cycle the response is visible.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    start_c   = 1'b0;
    if (!wb.cyc) begin
      state_nxt = S_IDLE;
      wcnt_nxt  = '0;
    end else begin
      case (state)
        S_IDLE: start_c = (count != '0);
        S_WAIT: begin
          if (wcnt == '0) state_nxt = S_RESP;
          else            wcnt_nxt  = wcnt - WC_W'(1);
        end
        S_RESP: begin
          // count already excludes the entry answered this cycle
          if (count != '0) start_c = 1'b1;
          else             state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
      if (start_c) begin
        if (WAIT_STATES == 0) begin
          state_nxt = S_RESP;
        end else begin
          state_nxt = S_WAIT;
          wcnt_nxt  = WLOAD;
        end
      end
    end
    fire_c = (state_nxt == S_RESP);
    if (!wb.cyc)
      count_nxt = '0;
    else
      count_nxt = count + QC_W'(push_c) - QC_W'(fire_c);
  end

  // Control and response registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      wcnt    <= wcnt_nxt;
      count   <= count_nxt;
      stall_q <= (count_nxt == QFULL);
      if (!wb.cyc) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push_c) wr_ptr <= wr_ptr + QP_W'(1);
        if (fire_c) rd_ptr <= rd_ptr + QP_W'(1);
      end
      ack_q   <= fire_c & ~head_c.oor;
      err_q   <= fire_c & head_c.oor;
      rdata_q <= (fire_c & ~head_c.we & ~head_c.oor) ? ram[idx_c] : '0;
    end
  end

  // Request queue storage (not reset; validity tracked by count).
  always_ff @(posedge i_clk) begin
    if (push_c) q_mem[wr_ptr] <= req_c;
  end

  // Byte-lane RAM write, committed on the response edge of an in-range write.
  always_ff @(posedge i_clk) begin
    if (fire_c & head_c.we & ~head_c.oor) begin
      for (int b = 0; b < 4; b++) begin
        if (head_c.sel[b]) ram[idx_c][8*b +: 8] <= head_c.data[8*b +: 8];
      end
    end
  end

  assign wb.stall = stall_q;
  assign wb.ack   = ack_q;
  assign wb.err   = err_q;
  assign wb.rdata = rdata_q;

endmodule

// File: tb/tb_tiny_rv_wb_ram.sv
// Self-checking bench for tiny_rv_wb_ram: one instance with no wait states and one
// with three, sharing a request bus gated by dsel.
module tb_tiny_rv_wb_ram;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned BASE  = 32'h100;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we, dsel;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        stall, ack, err;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  tiny_rv_wb_ram_if if0 ();
  tiny_rv_wb_ram_if if3 ();

  assign if0.cyc = cyc & ~dsel;
  assign if0.stb = stb & ~dsel;
  assign if3.cyc = cyc & dsel;
  assign if3.stb = stb & dsel;
  assign if0.we = we;       assign if3.we = we;
  assign if0.addr = addr;   assign if3.addr = addr;
  assign if0.wdata = wdata; assign if3.wdata = wdata;
  assign if0.sel = sel;     assign if3.sel = sel;

  assign stall = dsel ? if3.stall : if0.stall;
  assign ack   = dsel ? if3.ack   : if0.ack;
  assign err   = dsel ? if3.err   : if0.err;
  assign rdata = dsel ? if3.rdata : if0.rdata;

  tiny_rv_wb_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0), .QUEUE_DEPTH(2))
    dut0 (.i_clk(clk), .i_reset(rst), .wb(if0.slave));
  tiny_rv_wb_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3), .QUEUE_DEPTH(2))
    dut3 (.i_clk(clk), .i_reset(rst), .wb(if3.slave));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits up to 12 edges for a response; checks latency, ack and read data.
  task automatic wait_resp(input string name, input int exp_lat, input logic [31:0] exp_data);
    int lat = 0;
    bit got = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      tick();
      if (ack | err) begin
        got = 1'b1;
        lat = c;
        chk({name, " ack"}, 32'(ack), 32'd1);
        chk({name, " data"}, rdata, exp_data);
      end
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
  endtask

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt [14];

  // random-phase reference model state
  logic [31:0] mm [DEPTH];
  bit          p_v;
  logic        p_we;
  logic [29:0] p_addr;
  logic [31:0] p_data;
  logic [3:0]  p_sel;

  initial begin
    #300000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic        e_ack, e_err;
    logic [31:0] e_data;
    int unsigned idx;
    bit          e_stall;

    vt[0]  = '{1'b1, 30'(BASE+5),  32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 30'(BASE+5),  32'h0,        4'hF, 1'b1, 1'b0, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 30'(BASE+6),  32'h11223344, 4'hF, 1'b1, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 30'(BASE+6),  32'hAABBCCDD, 4'h5, 1'b1, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 30'(BASE+6),  32'h0,        4'h0, 1'b1, 1'b0, 32'h11BB33DD};
    vt[5]  = '{1'b1, 30'(BASE+0),  32'h12345678, 4'hF, 1'b1, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 30'(BASE+16), 32'h0,        4'hF, 1'b0, 1'b1, 32'h0};
    vt[7]  = '{1'b1, 30'(BASE+16), 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 32'h0};
    vt[8]  = '{1'b0, 30'(BASE+0),  32'h0,        4'hF, 1'b1, 1'b0, 32'h12345678};
    vt[9]  = '{1'b0, 30'(BASE-1),  32'h0,        4'hF, 1'b0, 1'b1, 32'h0};
    vt[10] = '{1'b1, 30'(BASE+15), 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, 32'h0};
    vt[11] = '{1'b1, 30'(BASE+15), 32'h00000000, 4'h8, 1'b1, 1'b0, 32'h0};
    vt[12] = '{1'b0, 30'(BASE+15), 32'h0,        4'h3, 1'b1, 1'b0, 32'h00FEF00D};
    vt[13] = '{1'b0, 30'(BASE+5),  32'h0,        4'h0, 1'b1, 1'b0, 32'hDEADBEEF};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; dsel = 1'b0;
    addr = '0; wdata = '0; sel = '0;
    #12;
    for (int d = 0; d < 2; d++) begin
      dsel = d[0];
      #1;
      chk("reset ack", 32'(ack), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      chk("reset data", rdata, 32'd0);
      chk("reset stall", 32'(stall), 32'd0);
    end
    dsel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Table: single transactions on the zero-wait instance.
    cyc = 1'b1;
    foreach (vt[i]) begin
      stb = 1'b1; we = vt[i].we; addr = vt[i].addr; wdata = vt[i].data; sel = vt[i].sel;
      tick();
      stb = 1'b0;
      chk($sformatf("vec%0d early ack", i), 32'(ack | err), 32'd0);
      tick();
      chk($sformatf("vec%0d ack", i), 32'(ack), 32'(vt[i].exp_ack));
      chk($sformatf("vec%0d err", i), 32'(err), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d data", i), rdata, vt[i].exp_data);
      tick();
      chk($sformatf("vec%0d after", i), {30'd0, ack, err} | rdata, 32'd0);
    end

    // Random traffic on the zero-wait instance against a one-cycle-latency model:
    // an accepted request answers at the next edge if cyc is still high, else it is dropped.
    p_v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i < DEPTH) begin
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'(BASE + i);
        wdata = $urandom; sel = 4'hF;
      end else begin
        cyc   = ($urandom_range(9, 0) != 0);
        stb   = ($urandom_range(9, 0) < 7);
        we    = $urandom_range(1, 0) == 1;
        addr  = 30'($urandom_range(BASE + DEPTH + 1, BASE - 2));
        wdata = $urandom;
        sel   = 4'($urandom_range(15, 0));
      end
      @(posedge clk);
      e_ack = 1'b0; e_err = 1'b0; e_data = '0; e_stall = 1'b0;
      if (cyc) begin
        if (p_v) begin
          if (p_addr < 30'(BASE) || p_addr >= 30'(BASE + DEPTH)) begin
            e_err = 1'b1;
          end else begin
            e_ack = 1'b1;
            idx = int'(p_addr) - BASE;
            if (p_we) begin
              for (int b = 0; b < 4; b++)
                if (p_sel[b]) mm[idx][8*b +: 8] = p_data[8*b +: 8];
            end else begin
              e_data = mm[idx];
            end
          end
        end
        p_v = stb; p_we = we; p_addr = addr; p_data = wdata; p_sel = sel;
      end else begin
        p_v = 1'b0;
      end
      #1;
      chk($sformatf("rnd%0d ack", i), 32'(ack), 32'(e_ack));
      chk($sformatf("rnd%0d err", i), 32'(err), 32'(e_err));
      chk($sformatf("rnd%0d data", i), rdata, e_data);
      chk($sformatf("rnd%0d stall", i), 32'(stall), 32'(e_stall));
    end
    cyc = 1'b0; stb = 1'b0;
    tick();

    // Three wait states, full queue: 3rd request stalls until 1st ack, acks 4 apart.
    dsel = 1'b1; cyc = 1'b1;
    tick();
    stb = 1'b1; we = 1'b1; addr = 30'(BASE + 1); wdata = 32'h5A5A1234; sel = 4'hF;
    tick();
    chk("q stall after 1", 32'(stall), 32'd0);
    we = 1'b0;
    tick();
    for (int k = 1; k <= 13; k++) begin
      if (k > 1) tick();
      chk($sformatf("q k%0d stall", k), 32'(stall), 32'(k inside {1, 2, 3, 5, 6, 7}));
      chk($sformatf("q k%0d ack", k), 32'(ack), 32'(k inside {4, 8, 12}));
      chk($sformatf("q k%0d err", k), 32'(err), 32'd0);
      chk($sformatf("q k%0d data", k), rdata, (k == 8 || k == 12) ? 32'h5A5A1234 : 32'h0);
      if (k == 5) stb = 1'b0;
    end

    // Abort with a write and a read queued; stb held during cyc=0 must be ignored.
    tick();
    stb = 1'b1; we = 1'b1; addr = 30'(BASE + 1); wdata = 32'hBAD0BAD0;
    tick();
    we = 1'b0;
    tick();
    cyc = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("abort c%0d resp", k), 32'(ack | err), 32'd0);
      chk($sformatf("abort c%0d stall", k), 32'(stall), 32'd0);
    end
    stb = 1'b0; cyc = 1'b1;
    tick();
    stb = 1'b1; we = 1'b0; addr = 30'(BASE + 1);
    tick();
    stb = 1'b0;
    wait_resp("post-abort read", 4, 32'h5A5A1234);

    // Async reset in the middle of WAIT with a full queue.
    tick();
    stb = 1'b1; we = 1'b0; addr = 30'(BASE + 1);
    tick();
    tick();
    stb = 1'b0;
    tick();
    chk("pre-reset stall", 32'(stall), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid reset ack", 32'(ack), 32'd0);
    chk("mid reset err", 32'(err), 32'd0);
    chk("mid reset data", rdata, 32'd0);
    chk("mid reset stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("after reset resp", 32'(ack | err), 32'd0);
    stb = 1'b1; we = 1'b0; addr = 30'(BASE + 1);
    tick();
    stb = 1'b0;
    wait_resp("post-reset read", 4, 32'h5A5A1234);
    tick();
    chk("post-reset data clear", rdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
